// File: rtl/envelope_pkg.sv
// envelope_pkg: shared types and constants for the ADSR envelope peripheral.
package envelope_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } env_state_t;

  localparam logic [2:0] REG_CTRL    = 3'd0;
  localparam logic [2:0] REG_ATTACK  = 3'd1;
  localparam logic [2:0] REG_DECAY   = 3'd2;
  localparam logic [2:0] REG_SUSTAIN = 3'd3;
  localparam logic [2:0] REG_RELEASE = 3'd4;
  localparam logic [2:0] REG_STATUS  = 3'd5;

  localparam logic [7:0] LEVEL_MAX = 8'd255;

  // Byte-lane merge of a bus write into an existing register value.
  function automatic logic [31:0] strb_merge(input logic [31:0] old,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  wstrb);
    logic [31:0] merged;
    for (int b = 0; b < 4; b++) begin
      merged[8*b +: 8] = wstrb[b] ? wdata[8*b +: 8] : old[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/envelope_vca.sv
// envelope_vca: registered amplitude scaling, out = (in * (level + 1)) >> 8.
module envelope_vca (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] in,
  input  logic [7:0] level,
  output logic [7:0] out
);

  logic [16:0] product;

  // The +1 makes level 255 an exact pass-through while level 0 still mutes.
  assign product = {9'd0, in} * {8'd0, ({1'b0, level} + 9'd1)};

  // Output sample register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out <= 8'd0;
    end else begin
      out <= 8'(product >> 5'd8);
    end
  end

endmodule

// File: rtl/envelope.sv
// envelope: bus-mapped ADSR envelope generator; holds the register file,
// prescaler and phase FSM, and feeds the level into the VCA stage.
module envelope
  import envelope_pkg::*;
#(
  parameter int RATE_W = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid,
  output logic        ready,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [7:0]  in,
  output logic [7:0]  out,
  output logic        done,
  output logic        active
);

  logic              held;
  logic              gate;
  logic [RATE_W-1:0] rate_attack, rate_decay, rate_release, rate_cur;
  logic [RATE_W-1:0] presc, nxt_presc;
  logic [7:0]        sustain, level, nxt_level;
  env_state_t        state, nxt_state;
  logic              accept, is_write, ctrl_wr, tick, nxt_done;
  logic [2:0]        sel;
  logic [31:0]       read_val;
  logic              unused_addr;

  // held blocks a second access while the master keeps valid asserted.
  assign sel         = addr[4:2];
  assign accept      = valid && !ready && !held;
  assign is_write    = (wstrb != 4'd0);
  assign ctrl_wr     = accept && is_write && wstrb[0] && (sel == REG_CTRL);
  assign unused_addr = ^{addr[31:5], addr[1:0]};

  // Register read multiplexer.
  always_comb begin
    case (sel)
      REG_CTRL:    read_val = {31'd0, gate};
      REG_ATTACK:  read_val = 32'(rate_attack);
      REG_DECAY:   read_val = 32'(rate_decay);
      REG_SUSTAIN: read_val = {24'd0, sustain};
      REG_RELEASE: read_val = 32'(rate_release);
      REG_STATUS:  read_val = {16'd0, level, 5'd0, state};
      default:     read_val = 32'd0;
    endcase
  end

  // Bus handshake and rate/sustain register file.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready        <= 1'b0;
      held         <= 1'b0;
      rdata        <= 32'd0;
      rate_attack  <= {RATE_W{1'b0}};
      rate_decay   <= {RATE_W{1'b0}};
      rate_release <= {RATE_W{1'b0}};
      sustain      <= 8'd0;
    end else begin
      ready <= accept;
      held  <= accept || (held && valid);
      rdata <= (accept && !is_write) ? read_val : 32'd0;
      if (accept && is_write) begin
        case (sel)
          REG_ATTACK:  rate_attack  <= RATE_W'(strb_merge(32'(rate_attack), wdata, wstrb));
          REG_DECAY:   rate_decay   <= RATE_W'(strb_merge(32'(rate_decay), wdata, wstrb));
          REG_SUSTAIN: sustain      <= wstrb[0] ? wdata[7:0] : sustain;
          REG_RELEASE: rate_release <= RATE_W'(strb_merge(32'(rate_release), wdata, wstrb));
          default:     ;
        endcase
      end
    end
  end

  // Prescaler compare against the rate of the current phase.
  always_comb begin
    case (state)
      ST_ATTACK:  rate_cur = rate_attack;
      ST_DECAY:   rate_cur = rate_decay;
      ST_RELEASE: rate_cur = rate_release;
      default:    rate_cur = {RATE_W{1'b0}};
    endcase
  end

  assign tick = (presc >= rate_cur);

  // Next phase/level; a CTRL write takes priority over a level step.
  always_comb begin
    nxt_state = state;
    nxt_level = level;
    nxt_done  = 1'b0;
    if (ctrl_wr) begin
      if (wdata[1]) begin
        nxt_state = ST_ATTACK;
        nxt_level = 8'd0;
      end else if (!gate && wdata[0] && (state == ST_IDLE || state == ST_RELEASE)) begin
        nxt_state = ST_ATTACK;
      end else if (gate && !wdata[0] &&
                   (state == ST_ATTACK || state == ST_DECAY || state == ST_SUSTAIN)) begin
        nxt_state = ST_RELEASE;
      end else begin
        nxt_state = state;
      end
    end else begin
      case (state)
        ST_IDLE:    nxt_level = 8'd0;
        ST_ATTACK:  begin
          if (tick) begin
            if (level == LEVEL_MAX) nxt_state = ST_DECAY;
            else                    nxt_level = level + 8'd1;
          end else begin
            nxt_level = level;
          end
        end
        ST_DECAY:   begin
          if (tick) begin
            if (level > sustain) nxt_level = level - 8'd1;
            else                 nxt_state = ST_SUSTAIN;
          end else begin
            nxt_level = level;
          end
        end
        ST_SUSTAIN: nxt_level = sustain;
        ST_RELEASE: begin
          if (tick) begin
            if (level == 8'd0) begin
              nxt_state = ST_IDLE;
              nxt_done  = 1'b1;
            end else begin
              nxt_level = level - 8'd1;
            end
          end else begin
            nxt_level = level;
          end
        end
        default:    begin
          nxt_state = ST_IDLE;
          nxt_level = 8'd0;
        end
      endcase
    end
    if (nxt_state != state || (ctrl_wr && wdata[1])) begin
      nxt_presc = {RATE_W{1'b0}};
    end else if (tick) begin
      nxt_presc = {RATE_W{1'b0}};
    end else begin
      nxt_presc = presc + RATE_W'(1);
    end
  end

  // FSM state and registered status outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= ST_IDLE;
      level  <= 8'd0;
      presc  <= {RATE_W{1'b0}};
      gate   <= 1'b0;
      done   <= 1'b0;
      active <= 1'b0;
    end else begin
      state  <= nxt_state;
      level  <= nxt_level;
      presc  <= nxt_presc;
      gate   <= ctrl_wr ? wdata[0] : gate;
      done   <= nxt_done;
      active <= (nxt_state != ST_IDLE);
    end
  end

  envelope_vca u_vca (
    .clk    (clk),
    .resetn (resetn),
    .in     (in),
    .level  (level),
    .out    (out)
  );

endmodule
